// File: rtl/apb_onrdwr_regs.sv
// apb_onrdwr_regs: APB4 register slave with per-register access side effects.
// Ports: clk/rst, s_apb_* APB4 slave, hw_set sticky-set in, reg_q/rd_pulse/wr_pulse out.
module apb_onrdwr_regs #(
   parameter int                  ADDR_WIDTH  = 6,
   parameter int                  N_REGS      = 8,
   parameter logic [3*N_REGS-1:0] MODES       = '0,
   parameter int                  WAIT_STATES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_apb_psel,
   input  logic                   s_apb_penable,
   input  logic                   s_apb_pwrite,
   input  logic [2:0]             s_apb_pprot,
   input  logic [ADDR_WIDTH-1:0]  s_apb_paddr,
   input  logic [31:0]            s_apb_pwdata,
   input  logic [3:0]             s_apb_pstrb,
   output logic                   s_apb_pready,
   output logic [31:0]            s_apb_prdata,
   output logic                   s_apb_pslverr,
   input  logic [32*N_REGS-1:0]   hw_set,
   output logic [32*N_REGS-1:0]   reg_q,
   output logic [N_REGS-1:0]      rd_pulse,
   output logic [N_REGS-1:0]      wr_pulse
);

   localparam int IW = ADDR_WIDTH - 2;

   logic [IW-1:0]               idx;
   logic                        in_range;
   logic                        access;
   logic                        done;
   logic                        rd_done;
   logic                        wr_done;
   logic [2:0]                  cnt;
   logic [N_REGS-1:0]           sel_dec;
   logic [N_REGS-1:0]           rd_hit;
   logic [N_REGS-1:0]           wr_hit;
   logic [N_REGS-1:0][31:0]     regs;
   logic [N_REGS-1:0][31:0]     regs_d;
   logic [N_REGS-1:0][31:0]     hw;
   logic [31:0]                 rd_val;
   logic                        unused_bits;

   assign unused_bits = ^{s_apb_pprot, s_apb_paddr[1:0]};

   assign idx      = s_apb_paddr[ADDR_WIDTH-1:2];
   assign in_range = (32'(idx) < 32'(N_REGS));
   assign access   = s_apb_psel & s_apb_penable;

   // Gated by rst so an abandoned transfer never completes during reset.
   assign s_apb_pready = ~rst & access & (cnt == 3'(WAIT_STATES));
   assign done         = s_apb_pready;
   assign rd_done      = done & ~s_apb_pwrite & in_range;
   assign wr_done      = done & s_apb_pwrite & in_range;

   assign hw    = hw_set;
   assign reg_q = regs;

   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < N_REGS; i++) begin
         sel_dec[i] = (idx == IW'(i));
      end
   end

   assign rd_hit = sel_dec & {N_REGS{rd_done}};
   assign wr_hit = sel_dec & {N_REGS{wr_done}};

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (sel_dec[i]) rd_val = regs[i];
      end
   end

   assign s_apb_prdata  = rd_done ? rd_val : '0;
   assign s_apb_pslverr = done & ~in_range;

   // Software effect first, then hw_set ORed last so hardware wins.
   always_comb begin
      regs_d = regs;
      for (int i = 0; i < N_REGS; i++) begin
         if (wr_hit[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (s_apb_pstrb[b]) begin
                  case (MODES[3*i +: 3])
                     3'd3:    regs_d[i][8*b +: 8] = regs[i][8*b +: 8] & ~s_apb_pwdata[8*b +: 8];
                     3'd4:    regs_d[i][8*b +: 8] = regs[i][8*b +: 8] | s_apb_pwdata[8*b +: 8];
                     default: regs_d[i][8*b +: 8] = s_apb_pwdata[8*b +: 8];
                  endcase
               end
            end
         end else if (rd_hit[i]) begin
            case (MODES[3*i +: 3])
               3'd1:    regs_d[i] = '0;
               3'd2:    regs_d[i] = '1;
               default: regs_d[i] = regs[i];
            endcase
         end
         regs_d[i] = regs_d[i] | hw[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (~s_apb_psel | done) begin
         cnt <= '0;
      end else if (access) begin
         cnt <= cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs     <= '0;
         rd_pulse <= '0;
         wr_pulse <= '0;
      end else begin
         regs     <= regs_d;
         rd_pulse <= rd_hit;
         wr_pulse <= wr_hit;
      end
   end

endmodule
